// File: rtl/descrambler_pkg.sv
// rtl/descrambler_pkg.sv - shared constants and types for the 802.11a descrambler
package descrambler_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        SERVICE = 2'd2,
        PAYLOAD = 2'd3
    } dstate_t;

    localparam int SYNC_BITS    = 7;
    localparam int SERVICE_BITS = 16;
    localparam int TAP_HI       = 7;
    localparam int TAP_LO       = 4;
    localparam int LFSR_W       = 7;
    localparam int CNT_W        = 5;

    // x^7 + x^4 + 1 feedback over a register indexed [7:1], [1] newest
    function automatic logic lfsr_fb(input logic [LFSR_W:1] s);
        return s[TAP_HI] ^ s[TAP_LO];
    endfunction

endpackage

// File: rtl/descrambler_if.sv
// rtl/descrambler_if.sv - bit-serial receive stream and status bundle for the descrambler
interface descrambler_if;
    logic       InValid;
    logic       InBit;
    logic       InStart;
    logic       InLast;
    logic       OutValid;
    logic       OutBit;
    logic       OutLast;
    logic       Locked;
    logic [6:0] SyncState;
    logic       ServiceErr;
    logic       FrameErr;

    modport master (
        output InValid, InBit, InStart, InLast,
        input  OutValid, OutBit, OutLast, Locked, SyncState, ServiceErr, FrameErr
    );

    modport slave (
        input  InValid, InBit, InStart, InLast,
        output OutValid, OutBit, OutLast, Locked, SyncState, ServiceErr, FrameErr
    );
endinterface

// File: rtl/descrambler_lfsr.sv
// rtl/descrambler_lfsr.sv - 7-bit scrambler register with external load and feedback step
module descrambler_lfsr
    import descrambler_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              load,
    input  logic              step,
    input  logic              in_bit,
    output logic [LFSR_W:1]   state,
    output logic              fb
);

    assign fb = lfsr_fb(state);

    // load wins over step; the top never asserts both in one cycle
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= '0;
        end else if (load) begin
            state <= {state[LFSR_W-1:1], in_bit};
        end else if (step) begin
            state <= {state[LFSR_W-1:1], fb};
        end
    end

endmodule

// File: rtl/descrambler.sv
// rtl/descrambler.sv - recovers scrambler state from SERVICE, checks it, emits descrambled PSDU
module descrambler
    import descrambler_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    descrambler_if.slave bus
);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_BITS - 1);
    localparam logic [CNT_W-1:0] SVC_LAST  = CNT_W'(SERVICE_BITS - 1);

    dstate_t            fsm_state;
    logic [CNT_W-1:0]   cnt;
    logic [LFSR_W:1]    lfsr_state;
    logic               fb;
    logic               d;
    logic               lfsr_load;
    logic               lfsr_step;
    logic               svc_sticky;

    logic               out_valid;
    logic               out_bit;
    logic               out_last;
    logic               locked;
    logic [6:0]         sync_state;
    logic               service_err;
    logic               frame_err;

    assign d = bus.InBit ^ fb;

    // a start bit always restarts state recovery, whatever state we are in
    assign lfsr_load = bus.InValid && (bus.InStart || fsm_state == SYNC);
    assign lfsr_step = bus.InValid && !bus.InStart &&
                       (fsm_state == SERVICE || fsm_state == PAYLOAD);

    descrambler_lfsr u_lfsr (
        .Clock  (Clock),
        .Reset  (Reset),
        .load   (lfsr_load),
        .step   (lfsr_step),
        .in_bit (bus.InBit),
        .state  (lfsr_state),
        .fb     (fb)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            fsm_state   <= IDLE;
            cnt         <= '0;
            svc_sticky  <= 1'b0;
            out_valid   <= 1'b0;
            out_bit     <= 1'b0;
            out_last    <= 1'b0;
            locked      <= 1'b0;
            sync_state  <= '0;
            service_err <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            out_valid   <= 1'b0;
            out_bit     <= 1'b0;
            out_last    <= 1'b0;
            service_err <= 1'b0;
            frame_err   <= 1'b0;
            if (bus.InValid) begin
                if (bus.InStart) begin
                    locked     <= 1'b0;
                    svc_sticky <= 1'b0;
                    if (bus.InLast) begin
                        frame_err <= 1'b1;
                        fsm_state <= IDLE;
                        cnt       <= '0;
                    end else begin
                        fsm_state <= SYNC;
                        cnt       <= CNT_W'(1);
                    end
                end else begin
                    unique case (fsm_state)
                        IDLE: begin
                            frame_err <= 1'b1;
                        end
                        SYNC: begin
                            if (bus.InLast) begin
                                frame_err <= 1'b1;
                                locked    <= 1'b0;
                                fsm_state <= IDLE;
                                cnt       <= '0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                                if (cnt == SYNC_LAST) begin
                                    sync_state <= {lfsr_state[LFSR_W-1:1], bus.InBit};
                                    locked     <= 1'b1;
                                    fsm_state  <= SERVICE;
                                end
                            end
                        end
                        SERVICE: begin
                            if (bus.InLast) begin
                                frame_err <= 1'b1;
                                locked    <= 1'b0;
                                fsm_state <= IDLE;
                                cnt       <= '0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                                if (d) begin
                                    svc_sticky <= 1'b1;
                                end
                                if (cnt == SVC_LAST) begin
                                    service_err <= svc_sticky | d;
                                    fsm_state   <= PAYLOAD;
                                end
                            end
                        end
                        PAYLOAD: begin
                            out_valid <= 1'b1;
                            out_bit   <= d;
                            out_last  <= bus.InLast;
                            if (bus.InLast) begin
                                locked    <= 1'b0;
                                fsm_state <= IDLE;
                                cnt       <= '0;
                            end
                        end
                        default: begin
                            fsm_state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.OutValid   = out_valid;
    assign bus.OutBit     = out_bit;
    assign bus.OutLast    = out_last;
    assign bus.Locked     = locked;
    assign bus.SyncState  = sync_state;
    assign bus.ServiceErr = service_err;
    assign bus.FrameErr   = frame_err;

endmodule

// File: tb/tb_descrambler.sv
// tb/tb_descrambler.sv - self-checking bench for descrambler against a keystream model
module tb_descrambler;

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    descrambler_if bus();

    descrambler dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit cur_locked = 1'b0;
    bit payload_q[$];
    logic [6:0] last_sync;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycle();
        bus.InValid = 1'b0;
        bus.InBit   = 1'($urandom_range(1, 0));
        bus.InStart = 1'($urandom_range(1, 0));
        bus.InLast  = 1'($urandom_range(1, 0));
        @(posedge Clock);
        @(negedge Clock);
        chk("gap_valid",  32'(bus.OutValid),   32'd0);
        chk("gap_serr",   32'(bus.ServiceErr), 32'd0);
        chk("gap_ferr",   32'(bus.FrameErr),   32'd0);
        chk("gap_locked", 32'(bus.Locked),     32'(cur_locked));
    endtask

    // Keystream follows k[n] = k[n-7] ^ k[n-4], seeded with x7..x1 as k[-7]..k[-1].
    task automatic send_frame(input logic [6:0] seed, input int flip, input int stop_at,
                              input bit early_last, input bit gaps);
        bit kk[0:263];
        bit data[0:255];
        bit rx[0:255];
        int total;
        int last;
        bit svc_bad;
        logic [6:0] sync_exp;
        bit ended_early;
        total = 16 + payload_q.size();
        last  = (stop_at >= 0) ? stop_at : total - 1;
        for (int j = 0; j < 7; j++) kk[j] = seed[6-j];
        for (int j = 7; j < 264; j++) kk[j] = kk[j-7] ^ kk[j-4];
        for (int n = 0; n < total; n++) begin
            data[n] = (n < 16) ? (n == flip) : payload_q[n-16];
            rx[n]   = data[n] ^ kk[n+7];
        end
        for (int j = 0; j < 7; j++) sync_exp[6-j] = kk[j+7];
        svc_bad = (flip >= 7 && flip <= 15);
        for (int n = 0; n <= last; n++) begin
            if (gaps) begin
                while ($urandom_range(1, 0) == 1) idle_cycle();
            end
            bus.InValid = 1'b1;
            bus.InBit   = rx[n];
            bus.InStart = (n == 0);
            bus.InLast  = (n == total - 1) || (early_last && n == last);
            @(posedge Clock);
            @(negedge Clock);
            ended_early = early_last && n == last && n < 16;
            chk("out_valid", 32'(bus.OutValid),   32'(n >= 16));
            chk("out_bit",   32'(bus.OutBit),     32'((n >= 16) ? data[n] : 1'b0));
            chk("out_last",  32'(bus.OutLast),    32'(n == total - 1));
            chk("serr",      32'(bus.ServiceErr), 32'(n == 15 && svc_bad && !ended_early));
            chk("ferr",      32'(bus.FrameErr),   32'(ended_early));
            cur_locked = (n >= 6) && (n < total - 1) && !ended_early;
            chk("locked",    32'(bus.Locked),     32'(cur_locked));
            if (n >= 6 && !ended_early) begin
                chk("sync_state", 32'(bus.SyncState), 32'(sync_exp));
                last_sync = sync_exp;
            end
        end
        bus.InValid = 1'b0;
        bus.InStart = 1'b0;
        bus.InLast  = 1'b0;
    endtask

    task automatic zero_payload(input int len);
        payload_q.delete();
        for (int i = 0; i < len; i++) payload_q.push_back(1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.OutValid),   32'd0);
        chk({tag, "_bit"},   32'(bus.OutBit),     32'd0);
        chk({tag, "_last"},  32'(bus.OutLast),    32'd0);
        chk({tag, "_lock"},  32'(bus.Locked),     32'd0);
        chk({tag, "_sync"},  32'(bus.SyncState),  32'd0);
        chk({tag, "_serr"},  32'(bus.ServiceErr), 32'd0);
        chk({tag, "_ferr"},  32'(bus.FrameErr),   32'd0);
    endtask

    initial begin
        logic [7:0] a5;
        logic [6:0] rseed;
        bit rand_pl[$];
        bus.InValid = 1'b0;
        bus.InBit   = 1'b0;
        bus.InStart = 1'b0;
        bus.InLast  = 1'b0;
        last_sync   = '0;

        repeat (3) @(negedge Clock);
        check_all_zero("reset");
        Reset = 1'b1;
        @(negedge Clock);

        // all-ones seed, zero SERVICE and 32 zero PSDU bits
        zero_payload(32);
        send_frame(7'b1111111, -1, -1, 1'b0, 1'b0);
        chk("sync_vector", 32'(bus.SyncState), 32'(7'b0000111));
        repeat (2) idle_cycle();

        // PSDU 0xA5 sent LSB first
        a5 = 8'hA5;
        payload_q.delete();
        for (int i = 0; i < 8; i++) payload_q.push_back(a5[i]);
        send_frame(7'b1011101, -1, -1, 1'b0, 1'b0);
        idle_cycle();

        // SERVICE bit 9 corrupted
        zero_payload(32);
        send_frame(7'b1111111, 9, -1, 1'b0, 1'b0);
        idle_cycle();

        // frame ends on SERVICE bit 10, then a clean frame
        send_frame(7'b1111111, -1, 10, 1'b1, 1'b0);
        idle_cycle();
        send_frame(7'b0110011, -1, -1, 1'b0, 1'b0);
        idle_cycle();

        // stray bit in IDLE without start
        bus.InValid = 1'b1;
        bus.InStart = 1'b0;
        bus.InLast  = 1'b0;
        bus.InBit   = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        chk("stray_ferr",  32'(bus.FrameErr), 32'd1);
        chk("stray_valid", 32'(bus.OutValid), 32'd0);
        bus.InValid = 1'b0;
        idle_cycle();

        // restart at PAYLOAD bit 5, second frame must decode cleanly
        zero_payload(24);
        payload_q[2] = 1'b1;
        send_frame(7'b1010101, -1, 20, 1'b0, 1'b0);
        send_frame(7'b0011100, -1, -1, 1'b0, 1'b0);
        idle_cycle();

        // asynchronous reset mid-PAYLOAD
        zero_payload(24);
        payload_q[10] = 1'b1;
        send_frame(7'b1110001, -1, 26, 1'b0, 1'b0);
        #2 Reset = 1'b0;
        #1 check_all_zero("async_reset");
        cur_locked = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        zero_payload(16);
        send_frame(7'b1011101, -1, -1, 1'b0, 1'b0);
        idle_cycle();

        // random frame, once gap-free and once with 50% valid duty
        rseed = 7'($urandom_range(127, 1));
        rand_pl.delete();
        for (int i = 0; i < 40; i++) rand_pl.push_back(1'($urandom_range(1, 0)));
        payload_q = rand_pl;
        send_frame(rseed, -1, -1, 1'b0, 1'b0);
        idle_cycle();
        payload_q = rand_pl;
        send_frame(rseed, -1, -1, 1'b0, 1'b1);
        repeat (2) idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/descrambler.md
# descrambler

Receive-side counterpart of the transmit scrambler. It accepts the demodulated, deinterleaved and decoded bit stream of one 802.11a frame (x^7 + x^4 + 1, bit-serial), recovers the scrambler state from the first 7 SERVICE bits, descrambles and checks the remainder of SERVICE, and emits the descrambled PSDU bits. It sits between the Viterbi decoder output and the receive MAC bit interface.

## Interface
- SYNC_BITS, 7, number of leading SERVICE bits used for state recovery; fixed, not overridable.
- SERVICE_BITS, 16, total SERVICE field length in bits; fixed.
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- InValid  input  1  InBit is valid this cycle; gaps are allowed.
- InBit  input  1  scrambled bit.
- InStart  input  1  qualified by InValid; marks SERVICE bit 0 of a new frame.
- InLast  input  1  qualified by InValid; marks the last bit of the frame.
- OutValid  output  1  OutBit is valid.
- OutBit  output  1  descrambled PSDU bit.
- OutLast  output  1  with OutValid; last PSDU bit.
- Locked  output  1  high from recovery of the scrambler state until the frame ends or aborts.
- SyncState  output  7  recovered LFSR state, {state[7:1]}.
- ServiceErr  output  1  one-cycle pulse: a descrambled SERVICE bit 7..15 was nonzero.
- FrameErr  output  1  one-cycle pulse: frame ended before payload, or InValid without InStart while IDLE.

## Operation
- States: IDLE, SYNC, SERVICE, PAYLOAD. The 5-bit bit counter cnt indexes SERVICE bits.
- Accepted bit = InValid high. There is no backpressure.
- IDLE: an accepted bit with InStart shifts it into the LFSR, sets cnt=1 and moves to SYNC. An accepted bit without InStart is dropped and pulses FrameErr.
- SYNC: each accepted bit loads the LFSR: state <= {state[6:1], InBit}. At cnt=6, set SyncState to the new state, assert Locked, set cnt=7 and move to SERVICE. Descrambled output for these bits is zero by definition and is not emitted.
- SERVICE (cnt 7..15): fb = state[7]^state[4]; d = InBit^fb; state <= {state[6:1], fb}. If d=1, latch a sticky error; at cnt=15 pulse ServiceErr if the error is set. Bits are not emitted. At cnt=15, move to PAYLOAD.
- PAYLOAD: same LFSR step. Emit OutBit=d and OutValid=1, with OutLast=InLast. InLast returns to IDLE.
- InLast in SYNC or SERVICE: pulse FrameErr, clear Locked, go to IDLE, no output.
- Accepted InStart in any non-IDLE state: the current frame is abandoned. No OutLast is generated and FrameErr is not asserted. The bit is treated as SERVICE bit 0 of a new frame (enter SYNC, cnt=1), and Locked is cleared.
- On the return to IDLE after PAYLOAD, Locked clears and SyncState holds its value.
- The ServiceErr sticky flag clears on InStart.

## Timing
- Reset (Reset low, asynchronous): state IDLE, LFSR 7'b0, cnt 0, SyncState 7'b0. OutValid, OutBit, OutLast, Locked, ServiceErr and FrameErr are all 0.
- All outputs are registered. OutBit/OutValid/OutLast appear 1 cycle after the accepted input bit.
- Locked and SyncState update in the cycle after SERVICE bit 6 is accepted.
- ServiceErr pulses in the cycle after bit 15 is accepted. FrameErr pulses in the cycle after the offending bit.
- With InValid low, nothing changes and OutValid is 0 the following cycle.
- Throughput is 1 bit per clock sustained.

## Structure
- Package descrambler_pkg holds the state enum (IDLE/SYNC/SERVICE/PAYLOAD), the SYNC_BITS and SERVICE_BITS constants, and the tap positions TAP_HI=7 and TAP_LO=4. The transmit scrambler shares these.
- Sub-module descrambler_lfsr: a 7-bit register with load (shift in an external bit) and step (shift in the feedback) modes, with fb as an output. The top level holds the FSM, the counter and the output registers.

## Test plan
- Seed 7'b1111111, 16 zero SERVICE bits plus 32 zero PSDU bits scrambled -> first 7 received bits 0000111, SyncState=7'b0000111, Locked, 32 OutBit=0, OutLast on bit 32, no errors.
- Seed 7'b1011101, PSDU 0xA5 (LSB first) -> output bits 1,0,1,0,0,1,0,1, OutLast on bit 8.
- Same as the first scenario with SERVICE bit 9 flipped -> one ServiceErr pulse 1 cycle after bit 15; payload is still emitted correctly.
- InLast on SERVICE bit 10 -> FrameErr pulse, Locked=0, no OutValid, and the next InStart frame decodes correctly.
- New InStart at PAYLOAD bit 5, and Reset asserted mid-PAYLOAD -> the second frame decodes with no OutLast from the first. After reset, all outputs are 0 immediately.
- Random InValid gaps (50% duty) -> output sequence identical to the gap-free run, each bit 1 cycle after its input.
